// File: rtl/decoder_3x8_pulse.sv
// Sequential 3-to-8 decoder: accepts a code over valid/ready, drives a one-hot
// pulse for PULSE_LEN cycles, then idles GAP_LEN cycles. DECODER_ACTIVE_LOW_EN inverts y.
module decoder_3x8_pulse #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] i,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] Y_IDLE = 8'hFF;
`else
    localparam logic [7:0] Y_IDLE = 8'h00;
`endif

    localparam logic [7:0] PULSE_CNT = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_CNT   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

    function automatic logic [7:0] decode(input logic [2:0] code);
        logic [7:0] onehot;
        onehot = 8'b1 << code;
`ifdef DECODER_ACTIVE_LOW_EN
        return ~onehot;
`else
        return onehot;
`endif
    endfunction

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign i_ready = en && (state_q == IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;

        case (state_q)
            IDLE: begin
                y_d = Y_IDLE;
                if (i_valid && i_ready) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_CNT;
                    y_d     = decode(i);
                end
            end
            PULSE: begin
                // y is held from the accepted code; i is ignored until IDLE.
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    y_d = Y_IDLE;
                    if (GAP_LEN != 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_CNT;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            GAP: begin
                y_d = Y_IDLE;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                y_d     = Y_IDLE;
            end
        endcase

        // Registered strobes are derived from the next state so they line up
        // with the cycle in which y shows the final pulse beat.
        done_d = (state_d == PULSE) && (cnt_d == 8'd0);
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            y_q     <= Y_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// Self-checking bench for decoder_3x8_pulse: a (PULSE_LEN=4, GAP_LEN=1) instance
// driven from a vector table plus sequences, and a (1, 0) instance for back-to-back codes.
module tb_decoder_3x8_pulse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       en_a = 1'b0, i_valid_a = 1'b0;
    logic [2:0] i_a = 3'd0;
    logic       i_ready_a, busy_a, done_a;
    logic [7:0] y_a;

    logic       en_b = 1'b0, i_valid_b = 1'b0;
    logic [2:0] i_b = 3'd0;
    logic       i_ready_b, busy_b, done_b;
    logic [7:0] y_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_3x8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .i(i_a), .i_valid(i_valid_a),
        .i_ready(i_ready_a), .y(y_a), .busy(busy_a), .done(done_a)
    );

    decoder_3x8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .i(i_b), .i_valid(i_valid_b),
        .i_ready(i_ready_b), .y(y_b), .busy(busy_b), .done(done_b)
    );

    // Map an active-high expectation onto the polarity the build uses.
    function automatic logic [7:0] pol(input logic [7:0] hi);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~hi;
`else
        return hi;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       valid;
        logic [2:0] code;
        logic [7:0] y_hi;
        logic       busy;
        logic       done;
        logic       ready;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    initial begin
        // Inputs applied before edge k; outputs expected in the same cycle.
        vecs[0]  = '{1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'd5, 8'h20, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 3'd2, 8'h04, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 3'd6, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 3'd6, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 3'd6, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 3'd6, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 3'd6, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1};

        // Reset state, asynchronous: outputs valid with no clock edge seen.
        #2;
        check("reset_y_a", y_a, pol(8'h00));
        check("reset_busy_a", busy_a, 0);
        check("reset_done_a", done_a, 0);
        check("reset_y_b", y_b, pol(8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven: basic pulse, en gating, i changing mid-pulse.
        for (int k = 0; k < NV; k++) begin
            en_a = vecs[k].en;
            i_valid_a = vecs[k].valid;
            i_a = vecs[k].code;
            #1;
            check($sformatf("vec%0d_y", k), y_a, pol(vecs[k].y_hi));
            check($sformatf("vec%0d_busy", k), busy_a, vecs[k].busy);
            check($sformatf("vec%0d_done", k), done_a, vecs[k].done);
            check($sformatf("vec%0d_ready", k), i_ready_a, vecs[k].ready);
            tick();
        end

        // Sweep 0..7 with i_valid held: accepts every 6 cycles, one bit at a time.
        en_a = 1'b1;
        i_valid_a = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [7:0] yh;
            i_a = 3'(c);
            #1;
            check($sformatf("sweep%0d_ready", c), i_ready_a, 1);
            tick();
            for (int p = 0; p < 4; p++) begin
                yh = pol(y_a);
                check($sformatf("sweep%0d_p%0d_y", c, p), y_a, pol(8'h01 << c));
                check($sformatf("sweep%0d_p%0d_onehot", c, p), $countones(yh), 1);
                check($sformatf("sweep%0d_p%0d_done", c, p), done_a, (p == 3) ? 1 : 0);
                tick();
            end
            check($sformatf("sweep%0d_gap_y", c), y_a, pol(8'h00));
            check($sformatf("sweep%0d_gap_busy", c), busy_a, 1);
            check($sformatf("sweep%0d_gap_ready", c), i_ready_a, 0);
            tick();
        end
        i_valid_a = 1'b0;
        #1;
        check("sweep_end_idle", busy_a, 0);

        // Asynchronous reset in the 2nd pulse cycle of code 7.
        i_a = 3'd7;
        i_valid_a = 1'b1;
        tick();
        i_valid_a = 1'b0;
        check("rst_pulse1_y", y_a, pol(8'h80));
        tick();
        check("rst_pulse2_y", y_a, pol(8'h80));
        rst_n = 1'b0;
        #1;
        check("rst_mid_y", y_a, pol(8'h00));
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_done", done_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_after_ready", i_ready_a, 1);
        check("rst_after_y", y_a, pol(8'h00));
        tick();
        check("rst_no_replay_y", y_a, pol(8'h00));
        check("rst_no_replay_busy", busy_a, 0);

        // PULSE_LEN=1, GAP_LEN=0: codes 0 then 1 back-to-back.
        en_b = 1'b1;
        i_valid_b = 1'b1;
        i_b = 3'd0;
        #1;
        check("b_ready0", i_ready_b, 1);
        tick();
        i_b = 3'd1;
        #1;
        check("b_y0", y_b, pol(8'h01));
        check("b_done0", done_b, 1);
        check("b_ready_in_pulse", i_ready_b, 0);
        tick();
        check("b_idle_y", y_b, pol(8'h00));
        check("b_idle_busy", busy_b, 0);
        check("b_idle_ready", i_ready_b, 1);
        tick();
        i_valid_b = 1'b0;
        #1;
        check("b_y1", y_b, pol(8'h02));
        check("b_done1", done_b, 1);
        tick();
        check("b_final_y", y_b, pol(8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
